// File: rtl/snn_spi_master.sv
// SPI mode-0 master that frames a 24-bit {cmd, addr, wdata} transfer to the SNN chip.
// MISO bits captured during the third byte are returned on rdata together with the done pulse.
module snn_spi_master #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] cmd,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       SCLK,
    output logic       MOSI,
    output logic       SS,
    input  logic       MISO
);

    localparam int unsigned CNT_W   = 8;
    localparam int unsigned IDX_W   = 6;
    localparam int unsigned FRAME_W = 24;
    localparam int unsigned BYTE_W  = 8;
    // MOSI itself holds the current bit, so only the remaining 23 bits are queued here
    localparam int unsigned TX_W    = FRAME_W - 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(47);

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [TX_W-1:0]   tx_q, tx_d;
    logic [BYTE_W-1:0] rx_q, rx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [BYTE_W-1:0] rdata_q, rdata_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic              ss_q, ss_d;
    logic              half_end;

    // Next-state and registered-output logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        rdata_d  = rdata_q;
        sclk_d   = sclk_q;
        mosi_d   = mosi_q;
        ss_d     = ss_q;
        half_end = (cnt_q == DIV_LAST);

        if (state_q != S_IDLE) begin
            cnt_d = half_end ? '0 : cnt_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SETUP;
                    cnt_d   = '0;
                    idx_d   = '0;
                    tx_d    = {cmd[6:0], addr, wdata};
                    rx_d    = '0;
                    busy_d  = 1'b1;
                    ss_d    = 1'b0;
                    sclk_d  = 1'b0;
                    mosi_d  = cmd[7];
                end
            end
            S_SETUP: begin
                if (half_end) begin
                    state_d = S_SHIFT;
                    sclk_d  = 1'b1;
                end
            end
            S_SHIFT: begin
                // even index = SCLK high; its first cycle is the rising-edge sample point
                if (!idx_q[0] && (cnt_q == '0)) begin
                    rx_d = {rx_q[BYTE_W-2:0], MISO};
                end
                if (half_end) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = S_HOLD;
                    end else begin
                        idx_d  = idx_q + IDX_W'(1);
                        sclk_d = ~sclk_q;
                        if (!idx_q[0]) begin
                            tx_d   = {tx_q[TX_W-2:0], 1'b0};
                            mosi_d = tx_q[TX_W-1];
                        end
                    end
                end
            end
            S_HOLD: begin
                if (half_end) begin
                    state_d = S_GAP;
                    ss_d    = 1'b1;
                    done_d  = 1'b1;
                    rdata_d = rx_q;
                    mosi_d  = 1'b0;
                end
            end
            S_GAP: begin
                if (half_end) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                busy_d  = 1'b0;
                ss_d    = 1'b1;
                sclk_d  = 1'b0;
                mosi_d  = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rdata_q <= '0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            ss_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            ss_q    <= ss_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign rdata = rdata_q;
    assign SCLK  = sclk_q;
    assign MOSI  = mosi_q;
    assign SS    = ss_q;

endmodule

// File: tb/tb_snn_spi_master.sv
// Bench for snn_spi_master: three instances (CLK_DIV 2, 1, 255) checked every cycle against a
// frame-timeline model, with random frames, mid-frame reset, held start and literal pins.
module tb_snn_spi_master;

    localparam int NI = 3;

    function automatic int cd_of(input int i);
        case (i)
            0:       return 2;
            1:       return 1;
            default: return 255;
        endcase
    endfunction

    logic clk = 1'b0;
    int   total = 0;
    int   bad = 0;

    logic       rst_a   [NI];
    logic       start_a [NI];
    logic [7:0] cmd_a   [NI];
    logic [7:0] addr_a  [NI];
    logic [7:0] wd_a    [NI];
    logic       busy_a  [NI];
    logic       done_a  [NI];
    logic [7:0] rdata_a [NI];
    logic       sclk_a  [NI];
    logic       mosi_a  [NI];
    logic       ss_a    [NI];

    bit          force3c   [NI];
    logic [23:0] word_a    [NI];
    int          idx_s     [NI];
    logic        sclk_prev [NI];

    // model: t = cycles since the accepting edge, -1 when idle
    int          t_m     [NI];
    logic [23:0] frame_m [NI];
    logic [7:0]  rdata_m [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        logic miso;
        assign miso = word_a[g][5'(23 - idx_s[g])];
        snn_spi_master #(.CLK_DIV((g == 0) ? 2 : (g == 1) ? 1 : 255)) u_dut (
            .clk   (clk),
            .reset (rst_a[g]),
            .start (start_a[g]),
            .cmd   (cmd_a[g]),
            .addr  (addr_a[g]),
            .wdata (wd_a[g]),
            .busy  (busy_a[g]),
            .done  (done_a[g]),
            .rdata (rdata_a[g]),
            .SCLK  (sclk_a[g]),
            .MOSI  (mosi_a[g]),
            .SS    (ss_a[g]),
            .MISO  (miso)
        );
    end

    // Frame timeline model: accept when idle, run 51*div cycles, deliver slave byte at SS rise
    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (rst_a[i]) begin
                t_m[i]     <= -1;
                rdata_m[i] <= 8'h00;
            end else if (t_m[i] < 0) begin
                if (start_a[i]) begin
                    t_m[i]     <= 0;
                    frame_m[i] <= {cmd_a[i], addr_a[i], wd_a[i]};
                end
            end else begin
                if (t_m[i] + 1 == 50 * cd_of(i)) rdata_m[i] <= word_a[i][7:0];
                t_m[i] <= (t_m[i] + 1 == 51 * cd_of(i)) ? -1 : t_m[i] + 1;
            end
        end
    end

    // SPI slave: new 24-bit word while deselected, next bit after each SCLK fall
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (ss_a[i] !== 1'b0) begin
                idx_s[i]  <= 0;
                word_a[i] <= force3c[i] ? {16'($urandom()), 8'h3C} : 24'($urandom());
            end else if (sclk_prev[i] && !sclk_a[i] && idx_s[i] < 23) begin
                idx_s[i] <= idx_s[i] + 1;
            end
            sclk_prev[i] <= sclk_a[i];
        end
    end

    task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s div=%0d got=%0h want=%0h at %0t", nm, cd_of(inst), act, exp, $time);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < NI; i++) begin
            int cd;
            int t;
            int n;
            logic [23:0] fr;
            bit sclk_e;
            cd = cd_of(i);
            t  = t_m[i];
            fr = frame_m[i];
            sclk_e = (t >= cd) && (t < 49 * cd) && (((t - cd) / cd) % 2 == 0);
            chk("busy", i, 32'(busy_a[i]), 32'(t >= 0));
            chk("ss", i, 32'(ss_a[i]), 32'(!(t >= 0 && t < 50 * cd)));
            chk("done", i, 32'(done_a[i]), 32'(t == 50 * cd));
            chk("sclk", i, 32'(sclk_a[i]), 32'(sclk_e));
            chk("rdata", i, 32'(rdata_a[i]), 32'(rdata_m[i]));
            if (t >= 0 && t < 49 * cd) begin
                n = (t < cd) ? 0 : ((t - cd) / cd + 1) / 2;
                if (n < 24) chk("mosi", i, 32'(mosi_a[i]), 32'(fr[23 - n]));
            end else if (t < 0 || t >= 50 * cd) begin
                chk("mosi_idle", i, 32'(mosi_a[i]), 32'(0));
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_all();
    endtask

    // mode 0: quiet, 1: start re-pulse at cycle 10 plus input change, 2: random input noise
    task automatic run_frame(input int i, input logic [23:0] f, input int mode,
                             output int busy_n, output int ss_lo, output int dn,
                             output int rises, output int hi_n, output logic [23:0] mosi_acc);
        bit prev;
        bit fin;
        busy_n = 0; ss_lo = 0; dn = 0; rises = 0; hi_n = 0; mosi_acc = '0;
        prev = 1'b0;
        fin  = 1'b0;
        {cmd_a[i], addr_a[i], wd_a[i]} = f;
        start_a[i] = 1'b1;
        step();
        start_a[i] = 1'b0;
        for (int k = 0; k < 51 * cd_of(i) + 20; k++) begin
            if (!busy_a[i]) begin
                fin = 1'b1;
                break;
            end
            busy_n++;
            if (!ss_a[i]) ss_lo++;
            if (done_a[i]) dn++;
            if (sclk_a[i]) begin
                hi_n++;
                if (!prev) begin
                    rises++;
                    mosi_acc = {mosi_acc[22:0], mosi_a[i]};
                end
            end
            prev = sclk_a[i];
            if (mode == 1) begin
                start_a[i] = (k == 10);
                if (k == 12) {cmd_a[i], addr_a[i], wd_a[i]} = 24'($urandom());
            end else if (mode == 2) begin
                start_a[i] = ($urandom_range(0, 3) == 0);
                {cmd_a[i], addr_a[i], wd_a[i]} = 24'($urandom());
            end
            step();
        end
        start_a[i] = 1'b0;
        chk("frame_end", i, 32'(fin), 32'(1));
    endtask

    initial begin
        int busy_n, ss_lo, dn, rises, hi_n, cd, ss_hi;
        logic [23:0] macc;
        bit prev, fin;

        for (int i = 0; i < NI; i++) begin
            rst_a[i] = 1'b1; start_a[i] = 1'b0; force3c[i] = 1'b0;
            cmd_a[i] = 8'h00; addr_a[i] = 8'h00; wd_a[i] = 8'h00;
        end
        step();
        start_a[0] = 1'b1;
        step();
        start_a[0] = 1'b0;
        for (int i = 0; i < NI; i++) begin
            chk("rst_ss", i, 32'(ss_a[i]), 32'(1));
            chk("rst_busy", i, 32'(busy_a[i]), 32'(0));
            chk("rst_rdata", i, 32'(rdata_a[i]), 32'(0));
            rst_a[i] = 1'b0;
        end
        step();

        for (int i = 0; i < NI; i++) begin
            cd = cd_of(i);

            // directed frame with a 0x3C third slave byte and an ignored second start
            force3c[i] = 1'b1;
            step();
            run_frame(i, 24'h0141A5, 1, busy_n, ss_lo, dn, rises, hi_n, macc);
            chk("dir_mosi", i, 32'(macc), 32'h0141A5);
            chk("dir_ss_low", i, 32'(ss_lo), (cd == 2) ? 32'd100 : (cd == 1) ? 32'd50 : 32'd12750);
            chk("dir_busy", i, 32'(busy_n), (cd == 2) ? 32'd102 : (cd == 1) ? 32'd51 : 32'd13005);
            chk("dir_sclk_hi", i, 32'(hi_n), (cd == 2) ? 32'd48 : (cd == 1) ? 32'd24 : 32'd6120);
            chk("dir_done", i, 32'(dn), 32'd1);
            chk("dir_rises", i, 32'(rises), 32'd24);
            chk("dir_rdata", i, 32'(rdata_a[i]), 32'h3C);
            force3c[i] = 1'b0;
            repeat (3) step();
            chk("dir_rdata_hold", i, 32'(rdata_a[i]), 32'h3C);

            // random frames with noisy inputs during busy
            for (int r = 0; r < ((cd > 100) ? 0 : 6); r++) begin
                repeat ($urandom_range(0, 3)) step();
                run_frame(i, 24'($urandom()), 2, busy_n, ss_lo, dn, rises, hi_n, macc);
                chk("rnd_done", i, 32'(dn), 32'd1);
                chk("rnd_rises", i, 32'(rises), 32'd24);
            end

            // reset at the 5th SCLK rise, with start asserted in the reset cycle
            {cmd_a[i], addr_a[i], wd_a[i]} = 24'($urandom());
            start_a[i] = 1'b1;
            step();
            start_a[i] = 1'b0;
            rises = 0; prev = 1'b0; fin = 1'b0;
            for (int k = 0; k < 20 * cd + 20; k++) begin
                if (sclk_a[i] && !prev) rises++;
                prev = sclk_a[i];
                if (rises == 5) begin
                    fin = 1'b1;
                    break;
                end
                step();
            end
            chk("abort_reach", i, 32'(fin), 32'd1);
            rst_a[i] = 1'b1;
            start_a[i] = 1'b1;
            step();
            rst_a[i] = 1'b0;
            start_a[i] = 1'b0;
            chk("abort_ss", i, 32'(ss_a[i]), 32'd1);
            chk("abort_sclk", i, 32'(sclk_a[i]), 32'd0);
            chk("abort_busy", i, 32'(busy_a[i]), 32'd0);
            dn = 0;
            repeat (2 * cd + 4) begin
                step();
                if (done_a[i]) dn++;
            end
            chk("abort_no_done", i, 32'(dn), 32'd0);
            run_frame(i, 24'($urandom()), 0, busy_n, ss_lo, dn, rises, hi_n, macc);
            chk("post_abort_done", i, 32'(dn), 32'd1);
            chk("post_abort_busy", i, 32'(busy_n), 32'(51 * cd));

            // start held high: back-to-back frames
            if (cd < 100) begin
                start_a[i] = 1'b1;
                dn = 0; rises = 0; prev = 1'b0; ss_hi = 0;
                for (int k = 0; k < 3 * (51 * cd + 2) + 10; k++) begin
                    {cmd_a[i], addr_a[i], wd_a[i]} = 24'($urandom());
                    step();
                    if (ss_a[i]) begin
                        ss_hi++;
                    end else begin
                        if (ss_hi > 0 && dn > 0) chk("held_gap", i, 32'(ss_hi), (cd == 1) ? 32'd2 : 32'd3);
                        ss_hi = 0;
                    end
                    if (sclk_a[i] && !prev) rises++;
                    prev = sclk_a[i];
                    if (done_a[i]) begin
                        dn++;
                        chk("held_rises", i, 32'(rises), 32'd24);
                        rises = 0;
                        if (dn == 3) begin
                            start_a[i] = 1'b0;
                            break;
                        end
                    end
                end
                start_a[i] = 1'b0;
                chk("held_frames", i, 32'(dn), 32'd3);
                fin = 1'b0;
                for (int k = 0; k < 60 * cd + 10; k++) begin
                    if (!busy_a[i]) begin
                        fin = 1'b1;
                        break;
                    end
                    step();
                end
                chk("held_idle", i, 32'(fin), 32'd1);
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
